// File: rtl/cp0_unit.sv
// CP0 system-control block: SR, Cause, EPC, PRId with exception entry/eret.
// Interrupts beat synchronous exceptions; reset is synchronous active-high.
module cp0_unit #(
  parameter logic [31:0] PRID = 32'h2024_0007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  a_addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic        req,
  output logic [31:0] epc_out
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] vbase;
  logic [31:0] dbase;
  logic        wr_sr;
  logic        wr_epc;

  assign int_req = ie_q & ~exl_q & (|(hw_int & im_q));
  assign exc_req = (|exc_code_in) & ~exl_q;
  assign req     = int_req | exc_req;
  assign epc_out = epc_q;

  assign vbase  = vpc & ~32'h3;
  assign dbase  = din & ~32'h3;
  assign wr_sr  = we && (a_addr == 5'd12);
  assign wr_epc = we && (a_addr == 5'd14);

  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    ip_d  = hw_int;
    exc_d = exc_q;
    epc_d = epc_q;
    if (req) begin
      exl_d = 1'b1;
      bd_d  = bd_in;
      exc_d = int_req ? 5'd0 : exc_code_in;
      epc_d = bd_in ? vbase - 32'd4 : vbase;
    end else begin
      if (wr_sr) begin
        im_d  = din[15:10];
        exl_d = din[1];
        ie_d  = din[0];
      end
      if (wr_epc) epc_d = dbase;
      // eret clears EXL after any same-cycle SR write
      if (eret) exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  always_comb begin
    dout = '0;
    case (a_addr)
      5'd12: dout = {16'h0, im_q, 8'h0, exl_q, ie_q};
      5'd13: dout = {bd_q, 15'h0, ip_q, 3'h0, exc_q, 2'h0};
      5'd14: dout = epc_q;
      5'd15: dout = PRID;
      default: dout = '0;
    endcase
  end

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 Parameter PRID, default 32'h2024_0007, value returned on reads of register 15.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-004 a_addr  input  5  CP0 register number for mfc0/mtc0 access.
REQ-005 we  input  1  mtc0 write enable.
REQ-006 din  input  32  mtc0 write data.
REQ-007 dout  output  32  mfc0 read data, combinational from a_addr.
REQ-008 vpc  input  32  PC of the instruction at the exception point (M stage).
REQ-009 bd_in  input  1  instruction at vpc sits in a branch delay slot.
REQ-010 exc_code_in  input  5  pending synchronous exception code; 0 = none.
REQ-011 hw_int  input  6  hardware interrupt lines; bit 0 = timer IRQ, bit 1 = second timer, bit 2 = external.
REQ-012 eret  input  1  eret retiring this cycle.
REQ-013 req  output  1  take exception/interrupt this cycle; pipeline flushes and fetches the handler.
REQ-014 epc_out  output  32  current EPC register value (eret target).

Function
REQ-015 Registers: SR (12), Cause (13), EPC (14), PRId (15); all other a_addr read 0 and ignore writes.
REQ-016 SR fields: IM = SR[15:10], EXL = SR[1], IE = SR[0]; all other SR bits read 0.
REQ-017 Cause fields: BD = Cause[31], IP = Cause[15:10], ExcCode = Cause[6:2]; all other bits read 0.
REQ-018 int_req = IE & ~EXL & |(hw_int & IM), computed combinationally from current-cycle hw_int.
REQ-019 exc_req = (exc_code_in != 0) & ~EXL.
REQ-020 req = int_req | exc_req, combinational, no registering.
REQ-021 Priority: int_req over exc_req; on int_req ExcCode is written 0 and exc_code_in is ignored.
REQ-022 On req at clk edge: EXL <= 1; Cause.BD <= bd_in; ExcCode <= 0 (interrupt) or exc_code_in; EPC <= bd_in ? {vpc[31:2],2'b00} - 4 : {vpc[31:2],2'b00}.
REQ-023 Cause.IP <= hw_int every cycle, regardless of IE, EXL, or req.
REQ-024 mtc0 to SR: SR <= din masked to IM/EXL/IE.
REQ-025 mtc0 to EPC: EPC <= {din[31:2],2'b00}.
REQ-026 mtc0 to Cause or PRId: no effect.
REQ-027 req and we in the same cycle: req update wins; the mtc0 write is discarded entirely.
REQ-028 eret with no req: EXL <= 0 at the clk edge; all other fields unchanged.
REQ-029 eret and we to SR in the same cycle: the SR write applies first, then EXL is forced to 0.
REQ-030 dout reflects register contents before the current edge; there is no write-to-read bypass.
REQ-031 epc_out reflects register contents before the current edge; there is no write-to-read bypass.
REQ-032 EPC arithmetic wraps modulo 2^32 (vpc = 0 with bd_in = 1 gives 32'hFFFF_FFFC).

Reset
REQ-033 On reset: SR = 0, Cause = 0, EPC = 0; req = 0 at the next cycle unless exc_code_in != 0.
REQ-034 Reset mid-handler (EXL = 1) clears EXL and discards any same-cycle req, we, or eret.

Verification
REQ-035 Timer interrupt: SR = 0000_0401 (IM[0] = 1, IE = 1), hw_int = 6'b000001, vpc = 0000_3010, bd_in = 0 -> req = 1; after the edge EXL = 1, EPC = 0000_3010, ExcCode = 0, IP = 000001.
REQ-036 Masked interrupt: SR = 0000_0801, hw_int = 6'b000001 -> req = 0; Cause reads 0000_0400.
REQ-037 Delay-slot exception: SR = 0, exc_code_in = 5'd4, vpc = 0000_3104, bd_in = 1 -> req = 1; EPC = 0000_3100, Cause = 8000_0010.
REQ-038 Nesting blocked: with EXL = 1, exc_code_in = 10 and hw_int = 3F -> req = 0; then eret -> EXL = 0; req rises the next cycle if IE = 1 and IM & hw_int != 0.
REQ-039 Conflict: we = 1, a_addr = 14, din = 1234_5678 in the same cycle as int_req, vpc = 0000_3200 -> EPC = 0000_3200; then an mtc0 with din = 1234_5677 -> EPC = 1234_5674.
REQ-040 Read map: a_addr = 15 -> dout = PRID; a_addr = 7 -> dout = 0; writes to 13 and 15 leave dout unchanged.
